// File: rtl/fs_pwm_multi.sv
// fs_pwm_multi: multi-channel PWM with a shared period counter and clock scaler.
// Build macro PWM_CENTER_EN selects centre-aligned up/down counting.
module fs_pwm_multi #(
  parameter int CH          = 4,
  parameter int DW          = 5,
  parameter int STEPS       = 20,
  parameter int CLK_DIV     = 5000,
  parameter int CLKOUT_HALF = 25
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             duty_wr,
  input  logic [CH*DW-1:0] duty_in,
  output logic             duty_pend,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start,
  output logic             clk_frame,
  output logic             clk_scaled
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int HW = (CLKOUT_HALF > 1) ? $clog2(CLKOUT_HALF) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEPS - 1);
  localparam logic [HW-1:0] HALF_MAX = HW'(CLKOUT_HALF - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nx;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_nx;
  logic [HW-1:0]    half_cnt;
  logic             en_q;
  logic             en_rise;
  logic             tick;
  logic             bnd;
  logic             xfer;
  logic             frame_nx;
  logic [CH*DW-1:0] shadow;
  logic [CH*DW-1:0] active;
  logic [CH*DW-1:0] active_nx;
  logic [CH-1:0]    pwm_nx;

  // A restart holds pre at 0 so the new period begins cleanly next cycle.
  assign en_rise = en & ~en_q;
  assign tick    = en & (pre == PRE_MAX);
  assign xfer    = bnd | en_rise;

  // Prescaler next value: cleared while idle or restarting, else wraps.
  always_comb begin
    pre_nx = pre + 1'b1;
    if (!en || en_rise || pre == PRE_MAX) pre_nx = '0;
  end

`ifdef PWM_CENTER_EN
  logic dn;
  logic dn_nx;

  assign bnd = tick & dn & (step == '0);

  // Up/down step sequencing; each end value is held for two ticks.
  always_comb begin
    step_nx = step;
    dn_nx   = dn;
    unique case (1'b1)
      !en || en_rise: begin
        step_nx = '0;
        dn_nx   = 1'b0;
      end
      tick && !dn && step == STEP_MAX:
        dn_nx = 1'b1;
      tick && !dn && step != STEP_MAX:
        step_nx = step + 1'b1;
      tick && dn && step == '0:
        dn_nx = 1'b0;
      tick && dn && step != '0:
        step_nx = step - 1'b1;
      default: ;
    endcase
  end

  // Direction register.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) dn <= 1'b0;
    else        dn <= dn_nx;
  end

  assign frame_nx = en & ~dn_nx;
`else
  localparam logic [SW-1:0] STEP_HALF = SW'(STEPS / 2);

  assign bnd = tick & (step == STEP_MAX);

  // Edge-aligned step sequencing.
  always_comb begin
    step_nx = step;
    unique case (1'b1)
      !en || en_rise || bnd: step_nx = '0;
      tick && !bnd:          step_nx = step + 1'b1;
      default: ;
    endcase
  end

  assign frame_nx = en & (step_nx < STEP_HALF);
`endif

  // Transfer uses the shadow as it stood before any same-cycle write.
  assign active_nx = (xfer && duty_pend) ? shadow : active;

  // Compare against the upcoming step so pwm edges line up with steps.
  always_comb begin
    pwm_nx = '0;
    for (int k = 0; k < CH; k++)
      pwm_nx[k] = en &&
        (32'(step_nx) < 32'(active_nx[k*DW +: DW]));
  end

  // Counters, duty buffers and registered outputs.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      step         <= '0;
      en_q         <= 1'b0;
      shadow       <= '0;
      active       <= '0;
      duty_pend    <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      clk_frame    <= 1'b0;
    end else begin
      pre          <= pre_nx;
      step         <= step_nx;
      en_q         <= en;
      active       <= active_nx;
      if (duty_wr) shadow <= duty_in;
      duty_pend    <= duty_wr | (duty_pend & ~xfer);
      pwm_out      <= pwm_nx;
      period_start <= xfer;
      clk_frame    <= frame_nx;
    end
  end

  // Free-running scaled clock, independent of en.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt   <= '0;
      clk_scaled <= 1'b0;
    end else if (half_cnt == HALF_MAX) begin
      half_cnt   <= '0;
      clk_scaled <= ~clk_scaled;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule
